// File: rtl/overpack_unpack_acc.sv
// Peels a 48-bit overpacked DSP word into NUM_FIELDS signed fields, one per cycle, accumulating each per field.
// Latency: word accepted -> 6 peel cycles; result valid the cycle after the last peel. Throughput 1 word / 7 cycles.
// Backpressure: in_ready low while peeling or holding; result held stable until out_ready. Macro OVERPACK_SAT_EN = saturating adds.
module overpack_unpack_acc #(
   parameter int FIELD_W      = 8,
   parameter int FIELD_STRIDE = 6,
   parameter int NUM_FIELDS   = 6,
   parameter int ACC_W        = 16
) (
   input  logic                        CLK,
   input  logic                        RST,
   input  logic [47:0]                 in_p,
   input  logic                        in_valid,
   input  logic                        in_last,
   output logic                        in_ready,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [NUM_FIELDS*ACC_W-1:0] out_acc,
   output logic                        busy
);
   localparam int KW = $clog2(NUM_FIELDS);
   localparam int RW = 49;

   typedef enum logic [1:0] {S_IDLE, S_PEEL, S_HOLD} state_t;

   state_t                   r_state;
   logic signed [RW-1:0]     r_res;
   logic [KW-1:0]            r_k;
   logic                     r_last;
   logic                     r_in_ready;
   logic                     r_out_valid;
   logic                     r_busy;
   logic signed [ACC_W-1:0]  r_acc [NUM_FIELDS];

   logic signed [FIELD_W-1:0] w_f;
   logic signed [RW-1:0]      w_f_ext;
   logic signed [RW-1:0]      w_f_sh;
   logic signed [ACC_W-1:0]   w_f_acc;
   logic signed [ACC_W-1:0]   w_acc_cur;
   logic signed [ACC_W-1:0]   w_acc_nxt;
`ifdef OVERPACK_SAT_EN
   logic signed [ACC_W:0]     w_sum;
`endif

   always_comb begin
      w_f       = r_res[r_k*FIELD_STRIDE +: FIELD_W];
      w_f_ext   = {{(RW-FIELD_W){w_f[FIELD_W-1]}}, w_f};
      w_f_sh    = w_f_ext << (r_k*FIELD_STRIDE);
      w_f_acc   = {{(ACC_W-FIELD_W){w_f[FIELD_W-1]}}, w_f};
      w_acc_cur = r_acc[r_k];
`ifdef OVERPACK_SAT_EN
      // One guard bit: overflow shows as disagreement between the top two sum bits.
      w_sum = {w_acc_cur[ACC_W-1], w_acc_cur} + {w_f_acc[ACC_W-1], w_f_acc};
      if (w_sum[ACC_W] != w_sum[ACC_W-1])
         w_acc_nxt = w_sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      else
         w_acc_nxt = w_sum[ACC_W-1:0];
`else
      w_acc_nxt = w_acc_cur + w_f_acc;
`endif
   end

   always_comb begin
      out_acc = '0;
      for (int i = 0; i < NUM_FIELDS; i++)
         out_acc[i*ACC_W +: ACC_W] = r_acc[i];
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign busy      = r_busy;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state     <= S_IDLE;
         r_res       <= '0;
         r_k         <= '0;
         r_last      <= 1'b0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
         for (int i = 0; i < NUM_FIELDS; i++)
            r_acc[i] <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid && r_in_ready) begin
                  r_res      <= {in_p[47], in_p};
                  r_last     <= in_last;
                  r_k        <= '0;
                  r_state    <= S_PEEL;
                  r_in_ready <= 1'b0;
                  r_busy     <= 1'b1;
               end
            end
            S_PEEL: begin
               r_acc[r_k] <= w_acc_nxt;
               r_res      <= r_res - w_f_sh;
               r_k        <= r_k + KW'(1);
               if (r_k == KW'(NUM_FIELDS-1)) begin
                  if (r_last) begin
                     r_state     <= S_HOLD;
                     r_out_valid <= 1'b1;
                  end else begin
                     r_state    <= S_IDLE;
                     r_in_ready <= 1'b1;
                     r_busy     <= 1'b0;
                  end
               end
            end
            S_HOLD: begin
               if (out_ready) begin
                  for (int i = 0; i < NUM_FIELDS; i++)
                     r_acc[i] <= '0;
                  r_state     <= S_IDLE;
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_busy      <= 1'b0;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_overpack_unpack_acc.sv
// Directed bench for overpack_unpack_acc: reset, peel sign/overlap, multi-word vectors, backpressure, overflow.
module tb_overpack_unpack_acc;
   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic [47:0] in_p = '0;
   logic        in_valid = 1'b0;
   logic        in_last = 1'b0;
   logic        in_ready;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [95:0] out_acc;
   logic        busy;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [95:0] exp_acc;

   overpack_unpack_acc dut (
      .CLK(CLK), .RST(RST), .in_p(in_p), .in_valid(in_valid), .in_last(in_last),
      .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
      .out_acc(out_acc), .busy(busy)
   );

   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check1(input string tag, input logic obs, input logic exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   // Returns just after the accepting edge.
   task automatic send_word(input logic [47:0] p, input logic l);
      int n;
      n = 0;
      in_p = p; in_last = l; in_valid = 1'b1;
      while (!in_ready && n < 50) begin
         tick();
         n++;
      end
      if (n >= 50) check1("accept_timeout", in_ready, 1'b1);
      tick();
      in_valid = 1'b0;
   endtask

   task automatic wait_valid();
      int n;
      n = 0;
      while (!out_valid && n < 50) begin
         tick();
         n++;
      end
      check1("out_valid_timeout", out_valid, 1'b1);
   endtask

   task automatic take_result(input string tag, input logic [95:0] exp);
      wait_valid();
      check(tag, out_acc, exp);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check1({tag, "_drop"}, out_valid, 1'b0);
   endtask

   initial begin
      // Reset values
      tick(); tick();
      check1("rst_in_ready", in_ready, 1'b1);
      check1("rst_out_valid", out_valid, 1'b0);
      check1("rst_busy", busy, 1'b0);
      check("rst_out_acc", out_acc, '0);
      RST = 1'b0;
      tick();

      // Reset mid-PEEL of the second word, with acc0 already nonzero
      send_word(48'd5, 1'b0);
      repeat (6) tick();
      send_word(48'd5, 1'b0);
      tick(); tick();
      check1("mid_peel_busy", busy, 1'b1);
      RST = 1'b1;
      tick();
      check1("midrst_in_ready", in_ready, 1'b1);
      check1("midrst_busy", busy, 1'b0);
      check1("midrst_out_valid", out_valid, 1'b0);
      check("midrst_out_acc", out_acc, '0);
      RST = 1'b0;
      tick();
      send_word(48'd0, 1'b1);
      take_result("zero_word", '0);

      // Sign peel and latency
      send_word(48'hFFFF_FFFF_FFFD, 1'b1);
      for (int i = 0; i < 5; i++) begin
         tick();
         check1("lat_early_valid", out_valid, 1'b0);
      end
      tick();
      check1("lat_valid_on_time", out_valid, 1'b1);
      exp_acc = '0; exp_acc[15:0] = 16'hFFFD;
      take_result("sign_peel", exp_acc);

      // Overlap peel
      send_word(48'h1000, 1'b1);
      exp_acc = '0; exp_acc[31:16] = 16'd64;
      take_result("overlap_1_12", exp_acc);
      send_word(48'd5, 1'b1);
      exp_acc = '0; exp_acc[15:0] = 16'd5;
      take_result("overlap_5", exp_acc);

      // Multi-word vector
      for (int w = 0; w < 4; w++) begin
         send_word(48'd5, (w == 3));
         check1("multi_peel_in_ready", in_ready, 1'b0);
         check1("multi_peel_busy", busy, 1'b1);
         if (w < 3) begin
            repeat (6) tick();
            check1("multi_no_output", out_valid, 1'b0);
            check1("multi_idle_ready", in_ready, 1'b1);
         end
      end
      exp_acc = '0; exp_acc[15:0] = 16'd20;
      take_result("multi_word", exp_acc);

      // Backpressure; 0x3007 peels to 7, -64, 4 through the field overlap
      send_word(48'h3007, 1'b1);
      wait_valid();
      exp_acc = '0; exp_acc[15:0] = 16'd7; exp_acc[31:16] = 16'hFFC0; exp_acc[47:32] = 16'd4;
      in_p = 48'd5; in_last = 1'b1; in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         check1("bp_valid_hold", out_valid, 1'b1);
         check("bp_acc_hold", out_acc, exp_acc);
         check1("bp_in_ready", in_ready, 1'b0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check1("bp_release_valid", out_valid, 1'b0);
      check("bp_cleared", out_acc, '0);
      send_word(48'd5, 1'b1);
      exp_acc = '0; exp_acc[15:0] = 16'd5;
      take_result("after_bp", exp_acc);

      // Overflow: 300 * 127 = 38100
      for (int w = 0; w < 300; w++)
         send_word(48'd127, (w == 299));
      exp_acc = '0;
`ifdef OVERPACK_SAT_EN
      exp_acc[15:0] = 16'h7FFF;
`else
      exp_acc[15:0] = 16'h94D4;
`endif
      take_result("overflow", exp_acc);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/overpack_unpack_acc.md
Name: overpack_unpack_acc

Overview:
Receive end of the overpacked-DSP datapath. Takes the 48-bit packed DSP result word, serially peels it into NUM_FIELDS signed partial products, and accumulates each product into its own accumulator across a vector of words. The vector is delimited by in_last. The accumulator set is then presented on a valid/ready output for the next layer stage.

Parameters:
FIELD_W, 8, width of one packed signed product field.
FIELD_STRIDE, 6, bit offset between consecutive fields; fields overlap by FIELD_W-FIELD_STRIDE bits.
NUM_FIELDS, 6, fields per packed word; field k starts at bit k*FIELD_STRIDE.
ACC_W, 16, signed accumulator width per field.

Ports:
CLK  in  1  clock, all state on rising edge
RST  in  1  asynchronous active-high reset
in_p  in  48  packed DSP result word
in_valid  in  1  in_p/in_last valid
in_last  in  1  word is last of the vector
in_ready  out  1  block can accept a word
out_valid  out  1  out_acc holds a completed vector result
out_ready  in  1  consumer accepts out_acc
out_acc  out  NUM_FIELDS*ACC_W  accumulators; field k at [k*ACC_W +: ACC_W]
busy  out  1  FSM not in IDLE

Behaviour:
- Interface: one clock CLK; RST is asynchronous, active-high.
- Reset values:
  - FSM goes to IDLE.
  - All accumulators, the residue register R, the field index and the last flag are 0.
  - in_ready=1, out_valid=0, busy=0, out_acc=0.
- FSM states: IDLE, PEEL, HOLD.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: capture R<=sign-extended in_p (49-bit internal), last_q<=in_last, k<=0, go to PEEL.
- PEEL (one field per cycle, NUM_FIELDS cycles; in_ready=0):
  - f = signed R[k*FIELD_STRIDE +: FIELD_W].
  - acc[k] <= acc[k] + sign_ext(f), wrapping modulo 2^ACC_W.
  - R <= R - (sign_ext(f) << k*FIELD_STRIDE).
  - k <= k+1.
  - After k=NUM_FIELDS-1: go to HOLD if last_q, else to IDLE.
- HOLD:
  - out_valid=1; out_acc is stable while out_valid && !out_ready.
  - On out_ready: clear all accumulators, go to IDLE.
  - in_ready=0 throughout.
- Throughput and latency:
  - One word per NUM_FIELDS+1 cycles.
  - out_valid rises the cycle after the final PEEL cycle of the last word.
- Bits of R above the last field are discarded; no error is flagged.
- in_valid while in_ready=0 is ignored; the producer must hold the word until accepted.
- out_ready while out_valid=0 has no effect.
- RST asserted mid-PEEL or mid-HOLD aborts the vector immediately to reset state; partial accumulation is lost.
- A single-word vector (in_last on the first word) is legal.

Optional Feature:
OVERPACK_SAT_EN:
- Defined: each accumulator add saturates to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
- Not defined: accumulator adds wrap modulo 2^ACC_W.
- Peel arithmetic on R is identical in both builds.

Test Plan:
- Reset:
  - Assert RST mid-PEEL -> next edge all outputs are reset values, busy=0, in_ready=1.
  - Then a single word in_p=0, in_last=1 -> out_acc all 0 after 7 cycles.
- Sign peel:
  - in_p=48'hFFFF_FFFF_FFFD, in_last=1 -> acc0=-3, acc1..5=0.
  - out_valid asserts 7 cycles after acceptance.
- Overlap peel:
  - in_p=1<<12, in_last=1 -> acc1=64, all others 0.
  - in_p=5 -> acc0=5, others 0.
- Multi-word vector:
  - Four words each in_p=5, the 4th with in_last -> acc0=20.
  - in_ready low during each PEEL; no output before the 4th word.
- Backpressure:
  - Hold out_ready=0 for 10 cycles in HOLD -> out_valid and out_acc stable, in_valid ignored.
  - Then out_ready=1 -> accumulators cleared, next vector starts from 0.
- Overflow with ACC_W=16:
  - 300 words of in_p=127 -> acc0=38100 wrapped to -27436 without OVERPACK_SAT_EN.
  - Same stimulus with OVERPACK_SAT_EN -> acc0=32767.
